operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode-to-execute pipeline register placed directly downstream of the register bank read ports and register-index decoder.
- Captures the instruction word, both source operands and the destination index into a single-entry holding register with a valid/ready handshake.
- Applies operand forwarding from the execute and writeback stages, and SP (register 16) push/pop adjustment.
- Detects load-use hazards, stalls the upstream stage and inserts a bubble.

Parameters:
- XLEN, 32, data and instruction width.
- SP_IDX, 16, stack-pointer register index.
- SP_STEP, 4, stack-pointer increment/decrement amount.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream holds a decoded instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- ir_in  in  XLEN  instruction word.
- rs1_idx, rs2_idx  in  5  source indices from the decoder.
- wr_idx_in  in  5  destination index.
- wr_en_in  in  1  instruction writes a register.
- is_load_in  in  1  instruction is a load.
- rs1_data, rs2_data  in  XLEN  register bank read data.
- ex_wr_en  in  1  execute stage will write a register.
- ex_is_load  in  1  execute-stage instruction is a load.
- ex_wr_idx  in  5  execute-stage destination index.
- ex_wr_data  in  XLEN  execute-stage result.
- wb_wr_en  in  1  writeback stage is writing a register.
- wb_wr_idx  in  5  writeback-stage destination index.
- wb_data  in  XLEN  writeback-stage result.
- sp_incdec  in  2  same code as the register bank: 01 = +SP_STEP, 10 = -SP_STEP, other = none.
- flush  in  1  discard the held and incoming instruction.
- out_valid  out  1  held entry is valid.
- out_ready  in  1  execute stage consumes the held entry.
- out_ir  out  XLEN  held instruction word.
- out_op1, out_op2  out  XLEN  held, forwarded operands.
- out_wr_idx  out  5  held destination index.
- out_wr_en  out  1  held write enable.
- out_is_load  out  1  held load flag.
- hazard  out  1  load-use hazard detected this cycle (combinational).
- stall_count  out  STALL_CNT_W  saturating count of hazard cycles.

Behaviour:
- Reset: synchronous, active-high; all outputs and the stall counter clear to 0.
  - out_valid=0, out_ir=0, out_op1=0, out_op2=0, out_wr_idx=0, out_wr_en=0, out_is_load=0, stall_count=0.
  - in_ready=0 while rst=1.
- Operand select per source, evaluated combinationally on the incoming operands. Priority, first match wins:
  1. idx==0 -> 0.
  2. ex_wr_en and ex_wr_idx==idx and !ex_is_load -> ex_wr_data.
  3. wb_wr_en and wb_wr_idx==idx -> wb_data.
  4. idx==SP_IDX and sp_incdec==01 -> rs_data+SP_STEP.
  5. idx==SP_IDX and sp_incdec==10 -> rs_data-SP_STEP.
  6. Otherwise -> rs_data.
- Arithmetic: modulo 2^XLEN; wrap-around is silent.
- hazard = in_valid & ex_wr_en & ex_is_load & (ex_wr_idx!=0) & (ex_wr_idx==rs1_idx | ex_wr_idx==rs2_idx).
- Handshake: in_ready = !rst & !hazard & (!out_valid | out_ready).
  - An instruction is accepted when in_valid & in_ready.
  - Accept: all out_* registers load at the next edge and out_valid=1. Latency is 1 cycle.
  - Held entry with out_ready=0: all out_* registers hold, even if inputs change.
  - out_ready=1 and no accept: out_valid=0, which inserts a bubble. A hazard with a ready consumer therefore emits exactly one bubble per hazard cycle.
  - Simultaneous consume and accept: the new entry replaces the old one with no bubble.
- State machine on out_valid:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept, or on !out_ready.
  - FULL -> EMPTY on out_ready & !accept.
- Flush (priority below rst, above accept): next out_valid=0, and no accept occurs that cycle. Data registers may hold stale values.
- stall_count: increments by 1 each cycle hazard=1 and rst=0; saturates at all-ones; does not wrap. Flush does not clear it.
- Forwarding is never applied to idx 0, even when ex_wr_idx or wb_wr_idx is 0.

Test Plan:
- Reset then in_valid=1, ir_in=0x10000000, rs1=3/rs2=4, rs1_data=5, rs2_data=7 -> next cycle out_valid=1, out_op1=5, out_op2=7, out_ir=0x10000000.
- EX forward: rs1_idx=3, ex_wr_en=1, ex_wr_idx=3, ex_wr_data=0xAA, wb_wr_idx=3, wb_data=0xBB -> out_op1=0xAA. With ex_wr_en=0 -> out_op1=0xBB.
- SP adjust: rs1_idx=16, rs1_data=900, sp_incdec=01 -> out_op1=904. With sp_incdec=10 -> 896. With rs1_idx=0 and rs1_data=0x55 -> out_op1=0.
- Load-use: ex_is_load=1, ex_wr_en=1, ex_wr_idx=5, rs2_idx=5 for 2 cycles -> hazard=1, in_ready=0, out_valid=0 after the bubble, stall_count=2. Then ex_is_load=0 -> accepted.
- Backpressure: fill, hold out_ready=0 for 3 cycles while changing inputs -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new entry next cycle with no bubble.
- Flush and mid-op reset: flush=1 while FULL with in_valid=1 -> out_valid=0 next cycle. rst=1 mid-stream -> every output 0 next cycle, stall_count=0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute holding register: captures instruction and operands,
// forwards results from execute/writeback, adjusts SP on push/pop and
// stalls on load-use hazards.
module operand_fetch_stage #(
  parameter int XLEN        = 32,
  parameter int SP_IDX      = 16,
  parameter int SP_STEP     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        ir_in,
  input  logic [4:0]             rs1_idx,
  input  logic [4:0]             rs2_idx,
  input  logic [4:0]             wr_idx_in,
  input  logic                   wr_en_in,
  input  logic                   is_load_in,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic                   ex_wr_en,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_wr_idx,
  input  logic [XLEN-1:0]        ex_wr_data,
  input  logic                   wb_wr_en,
  input  logic [4:0]             wb_wr_idx,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [1:0]             sp_incdec,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_ir,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [4:0]             out_wr_idx,
  output logic                   out_wr_en,
  output logic                   out_is_load,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [4:0]      SP_IDX_L  = 5'(SP_IDX);
  localparam logic [XLEN-1:0] SP_STEP_L = XLEN'(SP_STEP);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q;
  logic [XLEN-1:0]        ir_q, op1_q, op2_q;
  logic [4:0]             wr_idx_q;
  logic                   wr_en_q, is_load_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [XLEN-1:0]        op1_d, op2_d;
  logic [STALL_CNT_W-1:0] stall_cnt_d;
  logic                   accept;

  // Forwarding priority: x0, EX (non-load), WB, SP adjust, bank data.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rs_data,
    input logic            f_ex_en,
    input logic            f_ex_ld,
    input logic [4:0]      f_ex_idx,
    input logic [XLEN-1:0] f_ex_data,
    input logic            f_wb_en,
    input logic [4:0]      f_wb_idx,
    input logic [XLEN-1:0] f_wb_data,
    input logic [1:0]      f_sp
  );
    if (idx == 5'd0)                                      return '0;
    else if (f_ex_en && (f_ex_idx == idx) && !f_ex_ld)    return f_ex_data;
    else if (f_wb_en && (f_wb_idx == idx))                return f_wb_data;
    else if ((idx == SP_IDX_L) && (f_sp == 2'b01))        return rs_data + SP_STEP_L;
    else if ((idx == SP_IDX_L) && (f_sp == 2'b10))        return rs_data - SP_STEP_L;
    else                                                  return rs_data;
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    if (&v) return v;
    else    return v + 1'b1;
  endfunction

  assign hazard = in_valid & ex_wr_en & ex_is_load & (ex_wr_idx != 5'd0) &
                  ((ex_wr_idx == rs1_idx) | (ex_wr_idx == rs2_idx));

  assign in_ready = !rst & !hazard & ((state_q == EMPTY) | out_ready);
  assign accept   = in_valid & in_ready & !flush;

  // Operand selection and stall-counter next value.
  always_comb begin
    op1_d       = sel_operand(rs1_idx, rs1_data, ex_wr_en, ex_is_load, ex_wr_idx,
                              ex_wr_data, wb_wr_en, wb_wr_idx, wb_data, sp_incdec);
    op2_d       = sel_operand(rs2_idx, rs2_data, ex_wr_en, ex_is_load, ex_wr_idx,
                              ex_wr_data, wb_wr_en, wb_wr_idx, wb_data, sp_incdec);
    stall_cnt_d = hazard ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Holding-register FSM: flush empties, accept loads, consume without accept bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ir_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      wr_idx_q    <= '0;
      wr_en_q     <= 1'b0;
      is_load_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush) begin
        state_q <= EMPTY;
      end else if (accept) begin
        state_q   <= FULL;
        ir_q      <= ir_in;
        op1_q     <= op1_d;
        op2_q     <= op2_d;
        wr_idx_q  <= wr_idx_in;
        wr_en_q   <= wr_en_in;
        is_load_q <= is_load_in;
      end else if (out_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_ir      = ir_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_wr_idx  = wr_idx_q;
  assign out_wr_en   = wr_en_q;
  assign out_is_load = is_load_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed-vector bench for operand_fetch_stage.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] ir_in;
  logic [4:0]  rs1_idx, rs2_idx, wr_idx_in;
  logic        wr_en_in, is_load_in;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_idx;
  logic [31:0] ex_wr_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_idx;
  logic [31:0] wb_data;
  logic [1:0]  sp_incdec;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_ir, out_op1, out_op2;
  logic [4:0]  out_wr_idx;
  logic        out_wr_en, out_is_load, hazard;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ir_in(ir_in), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .wr_idx_in(wr_idx_in), .wr_en_in(wr_en_in), .is_load_in(is_load_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_idx(ex_wr_idx),
    .ex_wr_data(ex_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_idx(wb_wr_idx),
    .wb_data(wb_data), .sp_incdec(sp_incdec), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
    .out_op1(out_op1), .out_op2(out_op2), .out_wr_idx(out_wr_idx),
    .out_wr_en(out_wr_en), .out_is_load(out_is_load), .hazard(hazard),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; ir_in = 0; rs1_idx = 0; rs2_idx = 0;
    wr_idx_in = 0; wr_en_in = 0; is_load_in = 0; rs1_data = 0; rs2_data = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_wr_idx = 0; ex_wr_data = 0;
    wb_wr_en = 0; wb_wr_idx = 0; wb_data = 0; sp_incdec = 0; flush = 0;
    out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_stall", 32'(stall_count), 0);
    rst = 1'b0;

    // Basic capture
    in_valid = 1; ir_in = 32'h1000_0000; rs1_idx = 3; rs2_idx = 4;
    rs1_data = 5; rs2_data = 7;
    #1 chk("empty_in_ready", 32'(in_ready), 1);
    step();
    chk("cap_valid", 32'(out_valid), 1);
    chk("cap_op1", out_op1, 5);
    chk("cap_op2", out_op2, 7);
    chk("cap_ir", out_ir, 32'h1000_0000);

    // EX beats WB; WB when EX idle
    ex_wr_en = 1; ex_wr_idx = 3; ex_wr_data = 32'hAA;
    wb_wr_en = 1; wb_wr_idx = 3; wb_data = 32'hBB;
    step();
    chk("fwd_ex", out_op1, 32'hAA);
    chk("fwd_ex_op2", out_op2, 7);
    ex_wr_en = 0;
    step();
    chk("fwd_wb", out_op1, 32'hBB);
    wb_wr_en = 0;

    // SP adjust, wrap, and x0
    rs1_idx = 16; rs1_data = 900; sp_incdec = 2'b01;
    step();
    chk("sp_inc", out_op1, 904);
    sp_incdec = 2'b10;
    step();
    chk("sp_dec", out_op1, 896);
    rs1_data = 2;
    step();
    chk("sp_wrap", out_op1, 32'hFFFF_FFFE);
    rs1_idx = 0; rs1_data = 32'h55; sp_incdec = 0;
    ex_wr_en = 1; ex_wr_idx = 0; ex_wr_data = 32'h99;
    wb_wr_en = 1; wb_wr_idx = 0; wb_data = 32'h98;
    step();
    chk("x0_zero", out_op1, 0);
    ex_wr_en = 0; wb_wr_en = 0;

    // Load-use hazard for two cycles
    rs1_idx = 1; rs1_data = 32'h11; rs2_idx = 5; rs2_data = 32'h77;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_idx = 5; ex_wr_data = 32'h123;
    #1;
    chk("hz_flag", 32'(hazard), 1);
    chk("hz_in_ready", 32'(in_ready), 0);
    step();
    chk("hz_bubble", 32'(out_valid), 0);
    chk("hz_stall1", 32'(stall_count), 1);
    step();
    chk("hz_stall2", 32'(stall_count), 2);
    chk("hz_still_empty", 32'(out_valid), 0);
    ex_is_load = 0;
    #1 chk("hz_clear_ready", 32'(in_ready), 1);
    step();
    chk("hz_accept_valid", 32'(out_valid), 1);
    chk("hz_accept_op2", out_op2, 32'h123);
    chk("hz_stall_hold", 32'(stall_count), 2);
    ex_wr_en = 0;

    // Backpressure
    ir_in = 32'h2222; rs1_idx = 2; rs1_data = 32'h11; rs2_idx = 6; rs2_data = 32'h66;
    step();
    chk("bp_fill", out_ir, 32'h2222);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      ir_in = 32'h3000 + 32'(i); rs1_data = 32'hF0 + 32'(i);
      #1 chk("bp_in_ready", 32'(in_ready), 0);
      step();
      chk("bp_hold_ir", out_ir, 32'h2222);
      chk("bp_hold_op1", out_op1, 32'h11);
      chk("bp_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1; ir_in = 32'h4444;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    step();
    chk("bp_new_ir", out_ir, 32'h4444);
    chk("bp_no_bubble", 32'(out_valid), 1);

    // Flush
    flush = 1; ir_in = 32'h5555;
    step();
    chk("flush_valid", 32'(out_valid), 0);
    flush = 0;
    step();
    chk("post_flush_ir", out_ir, 32'h5555);
    chk("flush_keeps_stall", 32'(stall_count), 2);

    // One more hazard cycle, then load nonzero fields and reset mid-stream
    ex_wr_en = 1; ex_is_load = 1; ex_wr_idx = 2;
    step();
    chk("hz_stall3", 32'(stall_count), 3);
    ex_wr_en = 0; ex_is_load = 0;
    wr_en_in = 1; wr_idx_in = 9; is_load_in = 1; ir_in = 32'h6666;
    step();
    chk("ld_wr_idx", 32'(out_wr_idx), 9);
    chk("ld_is_load", 32'(out_is_load), 1);
    rst = 1;
    step();
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_ir", out_ir, 0);
    chk("mrst_op1", out_op1, 0);
    chk("mrst_op2", out_op2, 0);
    chk("mrst_wr_idx", 32'(out_wr_idx), 0);
    chk("mrst_wr_en", 32'(out_wr_en), 0);
    chk("mrst_is_load", 32'(out_is_load), 0);
    chk("mrst_stall", 32'(stall_count), 0);
    chk("mrst_in_ready", 32'(in_ready), 0);
    rst = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
